sync_fifo: RTL and testbench

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/sync_fifo_if.sv | 30 +++
 rtl/sync_fifo.sv | 94 +++++++++
 tb/tb_sync_fifo.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_if.sv
// Write/read handshake and status bundle for sync_fifo.
// The FIFO sits on the slave side; the producer/consumer logic uses master.
interface sync_fifo_if #(
  parameter int pDATA_WIDTH = 16
);
  logic [31:0]            full_threshold_value;
  logic                   wen;
  logic [pDATA_WIDTH-1:0] wdata;
  logic                   full;
  logic                   almost_full;
  logic                   overflow;
  logic                   full_threshold;
  logic                   ren;
  logic [pDATA_WIDTH-1:0] rdata;
  logic                   empty;
  logic                   almost_empty;
  logic                   underflow;

  modport master (
    output full_threshold_value, wen, wdata, ren,
    input  full, almost_full, overflow, full_threshold,
    input  rdata, empty, almost_empty, underflow
  );

  modport slave (
    input  full_threshold_value, wen, wdata, ren,
    output full, almost_full, overflow, full_threshold,
    output rdata, empty, almost_empty, underflow
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with count-decoded status flags, registered or first-word-fall-through
// read mode, and selectable flop / block-RAM / distributed-RAM storage.
module sync_fifo #(
  parameter int pDATA_WIDTH  = 16,
  parameter int pDEPTH       = 512,
  parameter int pFALLTHROUGH = 0,
  parameter int pFLOPS       = 1,
  parameter int pBRAM        = 0,
  parameter int pDISTRIBUTED = 0
) (
  input logic       clk,
  input logic       rst,
  sync_fifo_if.slave bus
);

  localparam int AW = $clog2(pDEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [CW-1:0]          count;
  logic                   wr_accept;
  logic                   rd_accept;
  logic                   overflow_q;
  logic                   underflow_q;
  logic [pDATA_WIDTH-1:0] head;

  // Full/empty come from the registered count, so a full FIFO drops a write even
  // when a read is accepted in the same cycle, and likewise an empty one rejects reads.
  assign wr_accept = bus.wen && !bus.full;
  assign rd_accept = bus.ren && !bus.empty;

  assign bus.empty          = (count == CW'(0));
  assign bus.full           = (count == CW'(pDEPTH));
  assign bus.almost_empty   = (count <= CW'(1));
  assign bus.almost_full    = (count >= CW'(pDEPTH - 1));
  assign bus.full_threshold = (32'(count) >= bus.full_threshold_value);
  assign bus.overflow       = overflow_q;
  assign bus.underflow      = underflow_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + AW'(1);
      if (rd_accept) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_accept, rd_accept})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      overflow_q  <= bus.wen && bus.full;
      underflow_q <= bus.ren && bus.empty;
    end
  end

  // An explicit pFLOPS request wins; otherwise pBRAM, then pDISTRIBUTED, pick the RAM style.
  if (pBRAM != 0 && pFLOPS == 0) begin : g_bram
    (* ram_style = "block" *) logic [pDATA_WIDTH-1:0] mem [pDEPTH];
    always_ff @(posedge clk) begin
      if (wr_accept) mem[wr_ptr] <= bus.wdata;
    end
    assign head = mem[rd_ptr];
  end else if (pDISTRIBUTED != 0 && pFLOPS == 0) begin : g_dist
    (* ram_style = "distributed" *) logic [pDATA_WIDTH-1:0] mem [pDEPTH];
    always_ff @(posedge clk) begin
      if (wr_accept) mem[wr_ptr] <= bus.wdata;
    end
    assign head = mem[rd_ptr];
  end else begin : g_flops
    (* ram_style = "registers" *) logic [pDATA_WIDTH-1:0] mem [pDEPTH];
    always_ff @(posedge clk) begin
      if (wr_accept) mem[wr_ptr] <= bus.wdata;
    end
    assign head = mem[rd_ptr];
  end

  if (pFALLTHROUGH != 0) begin : g_fwft
    assign bus.rdata = bus.empty ? '0 : head;
  end else begin : g_reg
    logic [pDATA_WIDTH-1:0] rdata_q;
    // Only an accepted read loads the output register, so rejected reads leave it alone.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)            rdata_q <= '0;
      else if (rd_accept) rdata_q <= head;
    end
    assign bus.rdata = rdata_q;
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a queue scoreboard checks a 512-deep registered-mode
// instance every cycle, plus a short first-word-fall-through instance.
module tb_sync_fifo;

  localparam int DEPTH  = 512;
  localparam int THRESH = 384;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  sync_fifo_if #(.pDATA_WIDTH(16)) a_if ();
  sync_fifo_if #(.pDATA_WIDTH(16)) b_if ();

  sync_fifo #(
    .pDATA_WIDTH(16), .pDEPTH(DEPTH), .pFALLTHROUGH(0),
    .pFLOPS(1), .pBRAM(0), .pDISTRIBUTED(0)
  ) dut_a (
    .clk(clk),
    .rst(rst),
    .bus(a_if)
  );

  sync_fifo #(
    .pDATA_WIDTH(16), .pDEPTH(8), .pFALLTHROUGH(1),
    .pFLOPS(0), .pBRAM(0), .pDISTRIBUTED(1)
  ) dut_b (
    .clk(clk),
    .rst(rst),
    .bus(b_if)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] sb_a [$];
  logic [15:0] sb_b [$];
  int          m_count  = 0;
  logic [15:0] m_rdata  = '0;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock of traffic on instance A; the model decides acceptance from its own count.
  task automatic apply_stimulus(input logic w, input logic [15:0] d, input logic r);
    logic was_full, was_empty, acc_w, acc_r;
    was_full  = (m_count == DEPTH);
    was_empty = (m_count == 0);
    acc_w     = w && !was_full;
    acc_r     = r && !was_empty;
    a_if.wen   = w;
    a_if.wdata = d;
    a_if.ren   = r;
    @(posedge clk);
    #1;
    a_if.wen = 1'b0;
    a_if.ren = 1'b0;
    if (acc_r) m_rdata = sb_a.pop_front();
    if (acc_w) sb_a.push_back(d);
    m_count = m_count + (acc_w ? 1 : 0) - (acc_r ? 1 : 0);
    check_output("a_rdata",        32'(a_if.rdata),          32'(m_rdata));
    check_output("a_empty",        32'(a_if.empty),          32'(m_count == 0));
    check_output("a_full",         32'(a_if.full),           32'(m_count == DEPTH));
    check_output("a_almost_empty", 32'(a_if.almost_empty),   32'(m_count <= 1));
    check_output("a_almost_full",  32'(a_if.almost_full),    32'(m_count >= DEPTH - 1));
    check_output("a_full_thresh",  32'(a_if.full_threshold), 32'(m_count >= THRESH));
    check_output("a_overflow",     32'(a_if.overflow),       32'(w && was_full));
    check_output("a_underflow",    32'(a_if.underflow),      32'(r && was_empty));
  endtask

  initial begin
    a_if.full_threshold_value = 32'd0;
    a_if.wen = 1'b0; a_if.wdata = '0; a_if.ren = 1'b0;
    b_if.full_threshold_value = 32'd4;
    b_if.wen = 1'b0; b_if.wdata = '0; b_if.ren = 1'b0;

    // Reset state, including threshold tracking a zero threshold value.
    #12;
    check_output("rst_empty",        32'(a_if.empty),          32'd1);
    check_output("rst_almost_empty", 32'(a_if.almost_empty),   32'd1);
    check_output("rst_full",         32'(a_if.full),           32'd0);
    check_output("rst_almost_full",  32'(a_if.almost_full),    32'd0);
    check_output("rst_overflow",     32'(a_if.overflow),       32'd0);
    check_output("rst_underflow",    32'(a_if.underflow),      32'd0);
    check_output("rst_rdata",        32'(a_if.rdata),          32'd0);
    check_output("rst_thresh_zero",  32'(a_if.full_threshold), 32'd1);
    check_output("rst_b_empty",      32'(b_if.empty),          32'd1);
    check_output("rst_b_rdata",      32'(b_if.rdata),          32'd0);
    a_if.full_threshold_value = THRESH;
    #1;
    check_output("rst_thresh_384",   32'(a_if.full_threshold), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fill to full, then one rejected write and a quiet cycle to see the pulse drop.
    for (int i = 0; i < DEPTH; i++) apply_stimulus(1'b1, 16'(i), 1'b0);
    apply_stimulus(1'b1, 16'hFFFF, 1'b0);
    apply_stimulus(1'b0, 16'h0000, 1'b0);

    // Drain in order, then a rejected read and a quiet cycle.
    for (int i = 0; i < DEPTH; i++) apply_stimulus(1'b0, 16'h0000, 1'b1);
    apply_stimulus(1'b0, 16'h0000, 1'b1);
    apply_stimulus(1'b0, 16'h0000, 1'b0);

    // Read while empty is rejected but the simultaneous write lands.
    apply_stimulus(1'b1, 16'h7777, 1'b1);
    apply_stimulus(1'b0, 16'h0000, 1'b1);

    // Hold at 256 entries with concurrent read/write across several pointer wraps.
    for (int i = 0; i < 256; i++) apply_stimulus(1'b1, 16'(16'h1000 + i), 1'b0);
    for (int i = 0; i < 1000; i++) apply_stimulus(1'b1, 16'(16'h2000 + i), 1'b1);

    // Refill to full; a write with a read in the same cycle is still dropped.
    for (int i = 0; i < 256; i++) apply_stimulus(1'b1, 16'(16'h4000 + i), 1'b0);
    apply_stimulus(1'b1, 16'hBEEF, 1'b1);
    apply_stimulus(1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 411; i++) apply_stimulus(1'b0, 16'h0000, 1'b1);
    check_output("pre_reset_count", 32'(m_count), 32'd100);

    // Asynchronous reset away from the clock edge clears everything at once.
    #2;
    rst = 1'b1;
    #1;
    check_output("arst_empty",        32'(a_if.empty),          32'd1);
    check_output("arst_almost_empty", 32'(a_if.almost_empty),   32'd1);
    check_output("arst_almost_full",  32'(a_if.almost_full),    32'd0);
    check_output("arst_rdata",        32'(a_if.rdata),          32'd0);
    check_output("arst_thresh",       32'(a_if.full_threshold), 32'd0);
    sb_a.delete();
    m_count = 0;
    m_rdata = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply_stimulus(1'b1, 16'h1234, 1'b0);
    apply_stimulus(1'b0, 16'h0000, 1'b1);
    check_output("after_reset_data", 32'(a_if.rdata), 32'h1234);

    // Fall-through instance: head is visible without ren, ren pops it.
    b_if.wen = 1'b1; b_if.wdata = 16'hA5A5;
    @(posedge clk);
    #1;
    b_if.wen = 1'b0;
    check_output("fwft_empty_after_write", 32'(b_if.empty), 32'd0);
    check_output("fwft_rdata_after_write", 32'(b_if.rdata), 32'hA5A5);
    @(posedge clk);
    #1;
    check_output("fwft_rdata_hold", 32'(b_if.rdata), 32'hA5A5);
    b_if.ren = 1'b1;
    @(posedge clk);
    #1;
    b_if.ren = 1'b0;
    check_output("fwft_empty_after_pop", 32'(b_if.empty), 32'd1);

    for (int i = 0; i < 3; i++) begin
      b_if.wen = 1'b1; b_if.wdata = 16'(16'h0011 * (i + 1));
      sb_b.push_back(16'(16'h0011 * (i + 1)));
      @(posedge clk);
      #1;
    end
    b_if.wen = 1'b0;
    while (sb_b.size() > 0) begin
      check_output("fwft_head", 32'(b_if.rdata), 32'(sb_b.pop_front()));
      check_output("fwft_not_empty", 32'(b_if.empty), 32'd0);
      b_if.ren = 1'b1;
      @(posedge clk);
      #1;
      b_if.ren = 1'b0;
    end
    check_output("fwft_drained", 32'(b_if.empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
